act_unit: RTL and testbench
===========================

Name: act_unit

Overview:
- Activation stage that consumes the residual adder's output stream (res2ac) and drives the activated stream to the downstream writer (ac2ob).
- Applies one per-layer activation to every signed ABUF_DATA_WIDTH lane: bypass, ReLU, clipped ReLU or leaky ReLU.
- Each activation is selected by a 1-entry instruction that stays active for a programmed number of tlast-terminated packets.
- Throughput is 1 beat/cycle through a single registered output stage.

Parameters:
AXI_DATA_WIDTH, 128, stream data width in bits
ABUF_DATA_WIDTH, 8, lane width in bits; LANES = AXI_DATA_WIDTH/8
INSTR_WIDTH, 32, instruction width in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
status  out  32  [31:16] instructions retired, [15:0] instructions accepted
s_axis_act_instr_tready  out  1  instruction ready
s_axis_act_instr_tvalid  in  1  instruction valid
s_axis_act_instr_tdata  in  INSTR_WIDTH  [1:0] mode, [8:2] clip_max (unsigned), [24:9] num_pkts, [31:25] reserved
s_axis_res2ac_tready  out  1  input data ready
s_axis_res2ac_tvalid  in  1  input data valid
s_axis_res2ac_tdata  in  AXI_DATA_WIDTH  LANES signed lanes, lane i at bits [8i+7:8i]
s_axis_res2ac_tkeep  in  AXI_DATA_WIDTH/8  lane enables
s_axis_res2ac_tlast  in  1  end of packet
m_axis_ac2ob_tready  in  1  output ready
m_axis_ac2ob_tvalid  out  1  output valid
m_axis_ac2ob_tdata  out  AXI_DATA_WIDTH  activated lanes
m_axis_ac2ob_tkeep  out  AXI_DATA_WIDTH/8  registered copy of input tkeep
m_axis_ac2ob_tlast  out  1  registered copy of input tlast

Behaviour:
Reset values:
- Reset (clk, rst_n synchronous active-low) is legal mid-operation.
- FSM goes to IDLE; pkt_cnt, mode, clip_max and num_pkts all go to 0.
- status=0, m_axis_ac2ob_tvalid=0, tdata=0, tkeep=0, tlast=0.
- Any in-flight beat is discarded.

FSM states:
- IDLE: instr_tready=1, s_axis_res2ac_tready=0.
  - On instr handshake, latch mode/clip_max/num_pkts and clear pkt_cnt.
  - If num_pkts≠0, go to RUN.
  - If num_pkts=0, stay in IDLE; the instruction retires in the same cycle (both status halves increment) and no data is consumed.
- RUN: instr_tready=0, s_axis_res2ac_tready = ~m_tvalid | m_tready.
  - Each accepted beat with tlast increments pkt_cnt.
  - An accepted tlast beat with pkt_cnt==num_pkts-1 retires the instruction (status[31:16]+1) and returns to IDLE next cycle.
  - A new instruction can be accepted no earlier than the cycle after the last beat, even while that beat still sits in the output register.

Output register:
- Loads on input handshake; latency 1 cycle.
- tvalid set on load; cleared when an output handshake occurs without a load in the same cycle.
- Simultaneous output handshake and load keeps tvalid=1 with the new beat.
- With tvalid=1 and tready=0, all outputs hold stable and input tready=0.

Per-lane arithmetic (x signed 8-bit):
- mode 0: y=x.
- mode 1: y = x<0 ? 0 : x.
- mode 2: y = x<0 ? 0 : min(x, clip_max); clip_max=0 forces all lanes to 0.
- mode 3: y = x<0 ? x>>>3 (arithmetic, rounds toward −inf) : x.
- Lanes whose tkeep bit is 0 output 0.
- No overflow is possible; results always fit 8 bits.

Status counters:
- Both halves are 16-bit and wrap 0xFFFF→0.

Test Plan:
- Bypass, mode 0, num_pkts=1: one beat with lanes {−128, −1, 0, 127}, tkeep=0xFFFF, tlast=1 → identical data one cycle later; FSM back to IDLE; status=0x0001_0001.
- ReLU, mode 1, num_pkts=2: packets of 3 and 2 beats, lanes −5 and 9 → outputs 0 and 9; tlast on output beats 3 and 5; instr_tready low until the cycle after beat 5.
- Clip, mode 2, clip_max=6: lanes {−3, 4, 6, 7, 127} → {0, 4, 6, 6, 6}. Same input with clip_max=0 → all lanes 0.
- Leaky, mode 3: lanes {−1, −8, −9, −128, 10} → {−1, −1, −2, −16, 10}. With tkeep=0x00FF, lanes 8–15 → 0.
- Backpressure: m_tready toggles every other cycle during a 16-beat packet → no beat lost or duplicated; data stable while stalled; s_tready=0 exactly when stalled. num_pkts=0 instruction → retires immediately, status increments, no data consumed.
- Reset mid-packet: assert rst_n=0 for 1 cycle with tvalid=1 and m_tready=0 → tvalid=0, status=0, IDLE, instr_tready=1 on the next cycle.

Source files
------------

// File: rtl/act_unit_if.sv
// act_unit_if: instruction, input and output streams of the activation stage
interface act_unit_if #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int INSTR_WIDTH    = 32
);
  logic                        s_axis_act_instr_tready;
  logic                        s_axis_act_instr_tvalid;
  logic [INSTR_WIDTH-1:0]      s_axis_act_instr_tdata;
  logic                        s_axis_res2ac_tready;
  logic                        s_axis_res2ac_tvalid;
  logic [AXI_DATA_WIDTH-1:0]   s_axis_res2ac_tdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axis_res2ac_tkeep;
  logic                        s_axis_res2ac_tlast;
  logic                        m_axis_ac2ob_tready;
  logic                        m_axis_ac2ob_tvalid;
  logic [AXI_DATA_WIDTH-1:0]   m_axis_ac2ob_tdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axis_ac2ob_tkeep;
  logic                        m_axis_ac2ob_tlast;
  modport slave (
    output s_axis_act_instr_tready, s_axis_res2ac_tready,
           m_axis_ac2ob_tvalid, m_axis_ac2ob_tdata, m_axis_ac2ob_tkeep, m_axis_ac2ob_tlast,
    input  s_axis_act_instr_tvalid, s_axis_act_instr_tdata,
           s_axis_res2ac_tvalid, s_axis_res2ac_tdata, s_axis_res2ac_tkeep, s_axis_res2ac_tlast,
           m_axis_ac2ob_tready
  );
  modport master (
    input  s_axis_act_instr_tready, s_axis_res2ac_tready,
           m_axis_ac2ob_tvalid, m_axis_ac2ob_tdata, m_axis_ac2ob_tkeep, m_axis_ac2ob_tlast,
    output s_axis_act_instr_tvalid, s_axis_act_instr_tdata,
           s_axis_res2ac_tvalid, s_axis_res2ac_tdata, s_axis_res2ac_tkeep, s_axis_res2ac_tlast,
           m_axis_ac2ob_tready
  );
endinterface

// File: rtl/act_unit.sv
// act_unit: per-lane bypass/ReLU/clipped-ReLU/leaky-ReLU stage, one instruction per run of packets
module act_unit #(
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int ABUF_DATA_WIDTH = 8,
  parameter int INSTR_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  act_unit_if.slave   bus,
  output logic [31:0] status
);
  localparam int W     = ABUF_DATA_WIDTH;
  localparam int LANES = AXI_DATA_WIDTH / 8;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                    state;
  logic [1:0]                mode;
  logic [6:0]                clip_max;
  logic [15:0]               num_pkts, pkt_cnt, retired, accepted;
  logic                      out_valid, out_last;
  logic [AXI_DATA_WIDTH-1:0] out_data, act;
  logic [LANES-1:0]          out_keep;
  logic                      instr_hs, in_hs, unused_bits;
  logic [15:0]               new_num;
  assign new_num     = bus.s_axis_act_instr_tdata[24:9];
  assign unused_bits = ^bus.s_axis_act_instr_tdata[INSTR_WIDTH-1:25];
  assign bus.s_axis_act_instr_tready = state == IDLE;
  assign bus.s_axis_res2ac_tready    = state == RUN && (!out_valid || bus.m_axis_ac2ob_tready);
  assign instr_hs = bus.s_axis_act_instr_tvalid && bus.s_axis_act_instr_tready;
  assign in_hs    = bus.s_axis_res2ac_tvalid && bus.s_axis_res2ac_tready;
  assign bus.m_axis_ac2ob_tvalid = out_valid;
  assign bus.m_axis_ac2ob_tdata  = out_data;
  assign bus.m_axis_ac2ob_tkeep  = out_keep;
  assign bus.m_axis_ac2ob_tlast  = out_last;
  assign status = {retired, accepted};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [W-1:0] x, leak;
    assign x    = bus.s_axis_res2ac_tdata[W*i +: W];
    assign leak = x >>> 3;
    // negative lanes are zeroed except in leaky mode; clip only applies to non-negative lanes
    assign act[W*i +: W] = !bus.s_axis_res2ac_tkeep[i] ? '0 :
                           mode == 2'd0 ? x :
                           x[W-1] ? (mode == 2'd3 ? leak : '0) :
                           (mode == 2'd2 && x > W'(clip_max)) ? W'(clip_max) : x;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= '0;
      clip_max  <= '0;
      num_pkts  <= '0;
      pkt_cnt   <= '0;
      retired   <= '0;
      accepted  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (instr_hs) begin
        mode     <= bus.s_axis_act_instr_tdata[1:0];
        clip_max <= bus.s_axis_act_instr_tdata[8:2];
        num_pkts <= new_num;
        pkt_cnt  <= '0;
        accepted <= accepted + 16'd1;
        if (new_num == '0) retired <= retired + 16'd1;
        else state <= RUN;
      end
      if (in_hs) begin
        out_data <= act;
        out_keep <= bus.s_axis_res2ac_tkeep;
        out_last <= bus.s_axis_res2ac_tlast;
        if (bus.s_axis_res2ac_tlast) begin
          pkt_cnt <= pkt_cnt + 16'd1;
          if (pkt_cnt == num_pkts - 16'd1) begin
            retired <= retired + 16'd1;
            state   <= IDLE;
          end
        end
      end
      out_valid <= in_hs || (out_valid && !bus.m_axis_ac2ob_tready);
    end
  end
endmodule

// File: tb/tb_act_unit.sv
// tb_act_unit: directed stimulus with a scoreboard of expected output beats
module tb_act_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] status;
  act_unit_if #(.AXI_DATA_WIDTH(128), .INSTR_WIDTH(32)) bus ();
  act_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .status(status));
  always #5 clk = ~clk;
  typedef struct packed {logic [127:0] d; logic [15:0] k; logic l;} beat_t;
  beat_t q[$];
  int n_cmp = 0, n_bad = 0, n_out = 0;
  int cur_mode = 0, cur_clip = 0;
  logic  stalled = 1'b0;
  beat_t held;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(logic [127:0] d, logic [15:0] k, int m, int c);
    logic [127:0] r;
    int x, y;
    for (int i = 0; i < 16; i++) begin
      x = int'($signed(d[8*i +: 8]));
      if (!k[i]) y = 0;
      else if (m == 0) y = x;
      else if (x < 0) y = (m == 3) ? (x - 7) / 8 : 0;
      else if (m == 2 && x > c) y = c;
      else y = x;
      r[8*i +: 8] = y[7:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] pack(int a, int b, int c, int d, int e, int n);
    int v[5];
    logic [127:0] r;
    v = '{a, b, c, d, e};
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[i % n][7:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) stalled = 1'b0;
    else begin
      if (bus.m_axis_ac2ob_tvalid && !bus.m_axis_ac2ob_tready) begin
        check("stall_s_tready", bus.s_axis_res2ac_tready, 0);
        if (stalled) check("stall_hold", {bus.m_axis_ac2ob_tdata, bus.m_axis_ac2ob_tkeep, bus.m_axis_ac2ob_tlast}, held);
        held = '{bus.m_axis_ac2ob_tdata, bus.m_axis_ac2ob_tkeep, bus.m_axis_ac2ob_tlast};
        stalled = 1'b1;
      end else stalled = 1'b0;
      if (bus.m_axis_ac2ob_tvalid && bus.m_axis_ac2ob_tready) begin
        n_out++;
        if (q.size() == 0) check("sb_underflow", q.size(), 1);
        else begin
          beat_t e;
          e = q.pop_front();
          check("out_data", bus.m_axis_ac2ob_tdata, e.d);
          check("out_keep", bus.m_axis_ac2ob_tkeep, e.k);
          check("out_last", bus.m_axis_ac2ob_tlast, e.l);
        end
      end
      if (bus.s_axis_res2ac_tvalid && bus.s_axis_res2ac_tready)
        q.push_back('{model(bus.s_axis_res2ac_tdata, bus.s_axis_res2ac_tkeep, cur_mode, cur_clip),
                      bus.s_axis_res2ac_tkeep, bus.s_axis_res2ac_tlast});
    end
  end

  task automatic instr(input int m, input int c, input int n);
    logic ok = 1'b0;
    bus.s_axis_act_instr_tdata  = {7'd0, 16'(n), 7'(c), 2'(m)};
    bus.s_axis_act_instr_tvalid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.s_axis_act_instr_tready;
      @(posedge clk);
      #1;
    end
    bus.s_axis_act_instr_tvalid = 1'b0;
    check("instr_hs", ok, 1);
    cur_mode = m;
    cur_clip = c;
  endtask

  task automatic beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    logic ok = 1'b0;
    bus.s_axis_res2ac_tdata  = d;
    bus.s_axis_res2ac_tkeep  = k;
    bus.s_axis_res2ac_tlast  = l;
    bus.s_axis_res2ac_tvalid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.s_axis_res2ac_tready;
      @(posedge clk);
      #1;
    end
    bus.s_axis_res2ac_tvalid = 1'b0;
    check("beat_hs", ok, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (q.size() != 0 || bus.m_axis_ac2ob_tvalid); t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_q", q.size(), 0);
    check("drain_valid", bus.m_axis_ac2ob_tvalid, 0);
  endtask

  initial begin
    logic [127:0] d;
    int out0;
    bus.s_axis_act_instr_tvalid = 1'b0;
    bus.s_axis_act_instr_tdata  = '0;
    bus.s_axis_res2ac_tvalid    = 1'b0;
    bus.s_axis_res2ac_tdata     = '0;
    bus.s_axis_res2ac_tkeep     = '0;
    bus.s_axis_res2ac_tlast     = 1'b0;
    bus.m_axis_ac2ob_tready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", status, 0);
    check("rst_valid", bus.m_axis_ac2ob_tvalid, 0);
    check("rst_data", bus.m_axis_ac2ob_tdata, 0);
    check("rst_keep", bus.m_axis_ac2ob_tkeep, 0);
    check("rst_last", bus.m_axis_ac2ob_tlast, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_instr_ready", bus.s_axis_act_instr_tready, 1);
    check("idle_s_ready", bus.s_axis_res2ac_tready, 0);
    // bypass
    instr(0, 0, 1);
    d = pack(-128, -1, 0, 127, 0, 4);
    beat(d, 16'hFFFF, 1'b1);
    check("byp_valid", bus.m_axis_ac2ob_tvalid, 1);
    check("byp_data", bus.m_axis_ac2ob_tdata, d);
    check("byp_idle", bus.s_axis_act_instr_tready, 1);
    check("byp_status", status, 32'h0001_0001);
    drain();
    // ReLU, two packets of 3 and 2 beats
    instr(1, 0, 2);
    d = pack(-5, 9, 0, 0, 0, 2);
    beat(d, 16'hFFFF, 1'b0);
    beat(d, 16'hFFFF, 1'b0);
    beat(d, 16'hFFFF, 1'b1);
    check("relu_busy3", bus.s_axis_act_instr_tready, 0);
    beat(d, 16'hFFFF, 1'b0);
    check("relu_busy4", bus.s_axis_act_instr_tready, 0);
    beat(d, 16'hFFFF, 1'b1);
    check("relu_idle", bus.s_axis_act_instr_tready, 1);
    check("relu_data", bus.m_axis_ac2ob_tdata, pack(0, 9, 0, 0, 0, 2));
    check("relu_last", bus.m_axis_ac2ob_tlast, 1);
    check("relu_status", status, 32'h0002_0002);
    drain();
    // clipped ReLU
    d = pack(-3, 4, 6, 7, 127, 5);
    instr(2, 6, 1);
    beat(d, 16'hFFFF, 1'b1);
    check("clip6_data", bus.m_axis_ac2ob_tdata, pack(0, 4, 6, 6, 6, 5));
    drain();
    instr(2, 0, 1);
    beat(d, 16'hFFFF, 1'b1);
    check("clip0_data", bus.m_axis_ac2ob_tdata, 0);
    drain();
    // leaky ReLU, full and half keep
    d = pack(-1, -8, -9, -128, 10, 5);
    instr(3, 0, 2);
    beat(d, 16'hFFFF, 1'b1);
    check("leaky_data", bus.m_axis_ac2ob_tdata, pack(-1, -1, -2, -16, 10, 5));
    beat(d, 16'h00FF, 1'b1);
    check("leaky_keep_data", bus.m_axis_ac2ob_tdata, {64'd0, pack(-1, -1, -2, -16, 10, 5) & {64'd0, {64{1'b1}}}});
    check("leaky_keep", bus.m_axis_ac2ob_tkeep, 16'h00FF);
    drain();
    check("leaky_status", status, 32'h0005_0005);
    // backpressure over a 16-beat packet
    out0 = n_out;
    instr(1, 0, 1);
    fork
      for (int t = 0; t < 60; t++) begin
        bus.m_axis_ac2ob_tready = (t % 2 == 0);
        @(posedge clk);
        #1;
      end
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(b * 16 + i);
        beat(d, 16'hFFFF, b == 15);
      end
    join
    bus.m_axis_ac2ob_tready = 1'b1;
    drain();
    check("bp_count", n_out - out0, 16);
    // zero-packet instruction retires immediately
    instr(0, 0, 0);
    bus.s_axis_res2ac_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("n0_s_ready", bus.s_axis_res2ac_tready, 0);
    end
    bus.s_axis_res2ac_tvalid = 1'b0;
    check("n0_status", status, 32'h0007_0007);
    check("n0_q", q.size(), 0);
    // reset mid-packet with a stalled output
    @(posedge clk);
    #1;
    instr(0, 0, 1);
    beat(pack(1, 2, 3, 4, 5, 5), 16'hFFFF, 1'b0);
    bus.m_axis_ac2ob_tready  = 1'b0;
    bus.s_axis_res2ac_tvalid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.s_axis_res2ac_tvalid = 1'b0;
    q.delete();
    check("mrst_valid", bus.m_axis_ac2ob_tvalid, 0);
    check("mrst_data", bus.m_axis_ac2ob_tdata, 0);
    check("mrst_status", status, 0);
    check("mrst_instr_ready", bus.s_axis_act_instr_tready, 1);
    check("mrst_s_ready", bus.s_axis_res2ac_tready, 0);
    bus.m_axis_ac2ob_tready = 1'b1;
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
